// File: rtl/bram_access_pkg.sv
// Shared types and helpers for the BRAM access unit and its load formatter.
package bram_access_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } access_size_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    ISSUE_HI = 3'd2,
    WAIT     = 3'd3,
    RESP     = 3'd4
  } state_t;

  function automatic int size_bytes(access_size_t size);
    return 1 << size;
  endfunction

endpackage

// File: rtl/bram_load_formatter.sv
// Extracts a byte/half/word from one or two adjacent BRAM words and sign- or zero-extends it.
module bram_load_formatter
  import bram_access_pkg::*;
#(
  parameter int  BYTES_PER_WORD = 4,
  localparam int WORD_BITS      = 8 * BYTES_PER_WORD,
  localparam int OFF_BITS       = $clog2(BYTES_PER_WORD)
) (
  input  logic [WORD_BITS-1:0] lo_word,
  input  logic [WORD_BITS-1:0] hi_word,
  input  logic [OFF_BITS-1:0]  offset,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  output logic [WORD_BITS-1:0] data
);

  logic [WORD_BITS-1:0] aligned;
  logic                 sign_bit;
  logic                 fill;
  int                   nbytes;

  // hi_word supplies the bytes that spill past the end of lo_word.
  assign aligned = WORD_BITS'({hi_word, lo_word} >> {offset, 3'b000});
  assign nbytes  = size_bytes(access_size_t'(size));

  always_comb begin
    sign_bit = 1'b0;
    case (access_size_t'(size))
      SIZE_BYTE: sign_bit = aligned[7];
      SIZE_HALF: sign_bit = aligned[15];
      default:   sign_bit = 1'b0;
    endcase
  end

  assign fill = sign_ext & sign_bit;

  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
    assign data[8*gi +: 8] = (gi < nbytes) ? aligned[8*gi +: 8] : {8{fill}};
  end

endmodule

// File: rtl/bram_access_unit.sv
// Converts processor load/store requests into word-addressed cycles on one BRAM port.
// Define BRAM_ACCESS_MISALIGNED_SPLIT_EN to split word-crossing accesses into two BRAM cycles.
module bram_access_unit
  import bram_access_pkg::*;
#(
  parameter int  CAPACITY_BYTES = 128,
  parameter int  BYTES_PER_WORD = 4,
  localparam int ADDR_BITS      = $clog2(CAPACITY_BYTES),
  localparam int WORD_BITS      = 8 * BYTES_PER_WORD,
  localparam int OFF_BITS       = $clog2(BYTES_PER_WORD)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [1:0]                req_size,
  input  logic                      req_signed,
  input  logic [ADDR_BITS-1:0]      req_address,
  input  logic [WORD_BITS-1:0]      req_wr_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [WORD_BITS-1:0]      rsp_rd_data,
  output logic                      rsp_error,
  output logic [ADDR_BITS-1:0]      mem_address,
  output logic                      mem_rd_en,
  output logic [WORD_BITS-1:0]      mem_wr_data,
  output logic [BYTES_PER_WORD-1:0] mem_wr_en,
  input  logic [WORD_BITS-1:0]      mem_rd_data
);

  localparam int IDX_BITS = ADDR_BITS - OFF_BITS;

  state_t                    state_q, state_d;
  logic                      capture;
  logic                      req_cross;
  logic                      write_q;
  access_size_t              size_q;
  logic                      signed_q;
  logic [ADDR_BITS-1:0]      addr_q;
  logic [WORD_BITS-1:0]      wdata_q;
  logic [WORD_BITS-1:0]      rsp_data_q, rsp_data_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [OFF_BITS-1:0]       off_q;
  logic [IDX_BITS-1:0]       word_q;
  logic [BYTES_PER_WORD-1:0] lane_mask;
  logic [BYTES_PER_WORD-1:0] en_lo;
  logic [WORD_BITS-1:0]      data_lo;
  logic [WORD_BITS-1:0]      fmt_lo, fmt_hi, fmt_data;

  assign off_q  = addr_q[OFF_BITS-1:0];
  assign word_q = addr_q[ADDR_BITS-1:OFF_BITS];

  assign req_cross = (int'(req_address[OFF_BITS-1:0]) +
                      size_bytes(access_size_t'(req_size))) > BYTES_PER_WORD;

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rd_data = rsp_data_q;
  assign rsp_error   = rsp_err_q;

  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_mask
    assign lane_mask[gi] = (gi < size_bytes(size_q));
  end

`ifdef BRAM_ACCESS_MISALIGNED_SPLIT_EN
  localparam logic [IDX_BITS-1:0] IDX_ONE = IDX_BITS'(1);

  logic                        cross_q;
  logic [WORD_BITS-1:0]        lo_data_q;
  logic [2*BYTES_PER_WORD-1:0] wr_en_pair;
  logic [2*WORD_BITS-1:0]      wr_data_pair;
  logic [BYTES_PER_WORD-1:0]   en_hi;
  logic [WORD_BITS-1:0]        data_hi;

  // Bytes shifted past the top lane land in the next word starting at lane 0.
  assign wr_en_pair   = {{BYTES_PER_WORD{1'b0}}, lane_mask} << off_q;
  assign wr_data_pair = {{WORD_BITS{1'b0}}, wdata_q} << {off_q, 3'b000};
  assign en_lo        = wr_en_pair[BYTES_PER_WORD-1:0];
  assign en_hi        = wr_en_pair[2*BYTES_PER_WORD-1:BYTES_PER_WORD];
  assign data_lo      = wr_data_pair[WORD_BITS-1:0];
  assign data_hi      = wr_data_pair[2*WORD_BITS-1:WORD_BITS];

  assign fmt_lo = cross_q ? lo_data_q : mem_rd_data;
  assign fmt_hi = cross_q ? mem_rd_data : '0;
`else
  assign en_lo   = lane_mask << off_q;
  assign data_lo = wdata_q << {off_q, 3'b000};
  assign fmt_lo  = mem_rd_data;
  assign fmt_hi  = '0;
`endif

  bram_load_formatter #(
    .BYTES_PER_WORD(BYTES_PER_WORD)
  ) u_formatter (
    .lo_word (fmt_lo),
    .hi_word (fmt_hi),
    .offset  (off_q),
    .size    (size_q),
    .sign_ext(signed_q),
    .data    (fmt_data)
  );

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          capture    = 1'b1;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          if (access_size_t'(req_size) == SIZE_RSVD) begin
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end else if (req_cross) begin
`ifdef BRAM_ACCESS_MISALIGNED_SPLIT_EN
            state_d = ISSUE;
`else
            rsp_err_d = 1'b1;
            state_d   = RESP;
`endif
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = write_q ? RESP : WAIT;
`ifdef BRAM_ACCESS_MISALIGNED_SPLIT_EN
        if (cross_q) state_d = ISSUE_HI;
`endif
      end
      ISSUE_HI: state_d = write_q ? RESP : WAIT;
      WAIT: begin
        rsp_data_d = fmt_data;
        state_d    = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      size_q     <= SIZE_BYTE;
      signed_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
`ifdef BRAM_ACCESS_MISALIGNED_SPLIT_EN
      cross_q    <= 1'b0;
      lo_data_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      if (capture) begin
        write_q  <= req_write;
        size_q   <= access_size_t'(req_size);
        signed_q <= req_signed;
        addr_q   <= req_address;
        wdata_q  <= req_wr_data;
`ifdef BRAM_ACCESS_MISALIGNED_SPLIT_EN
        cross_q  <= req_cross;
`endif
      end
`ifdef BRAM_ACCESS_MISALIGNED_SPLIT_EN
      // Low-word read data arrives while the high-word read is being issued.
      if (state_q == ISSUE_HI) lo_data_q <= mem_rd_data;
`endif
    end
  end

  always_comb begin
    mem_address = {word_q, {OFF_BITS{1'b0}}};
    mem_wr_data = data_lo;
    mem_rd_en   = 1'b0;
    mem_wr_en   = '0;
    if (state_q == ISSUE) begin
      mem_rd_en = ~write_q;
      mem_wr_en = write_q ? en_lo : '0;
    end
`ifdef BRAM_ACCESS_MISALIGNED_SPLIT_EN
    if (state_q == ISSUE_HI) begin
      mem_address = {word_q + IDX_ONE, {OFF_BITS{1'b0}}};
      mem_wr_data = data_hi;
      mem_rd_en   = ~write_q;
      mem_wr_en   = write_q ? en_hi : '0;
    end
`endif
    if (reset) begin
      mem_rd_en = 1'b0;
      mem_wr_en = '0;
    end
  end

endmodule

// File: tb/tb_bram_access_unit.sv
// Directed self-checking bench for bram_access_unit with a simple 1-cycle-latency BRAM model.
module tb_bram_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [6:0]  req_address;
  logic [31:0] req_wr_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rd_data;
  logic        rsp_error;
  logic [6:0]  mem_address;
  logic        mem_rd_en;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_en;
  logic [31:0] mem_rd_data;

  int checks = 0;
  int errors = 0;

  int          lat;
  int          rd_count;
  logic [6:0]  rd_addr;
  logic [3:0]  wr_en_seen;
  logic [31:0] wr_data_seen;
  logic [31:0] rsp_data_seen;
  logic        rsp_err_seen;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  bram_access_unit #(
    .CAPACITY_BYTES(128),
    .BYTES_PER_WORD(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_address(req_address),
    .req_wr_data(req_wr_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rd_data(rsp_rd_data),
    .rsp_error  (rsp_error),
    .mem_address(mem_address),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_data(mem_wr_data),
    .mem_wr_en  (mem_wr_en),
    .mem_rd_data(mem_rd_data)
  );

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_address[6:2]];
    for (int i = 0; i < 4; i++) begin
      if (mem_wr_en[i]) mem[mem_address[6:2]][8*i +: 8] <= mem_wr_data[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where rsp_valid is first seen (or after a timeout).
  task automatic request(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [6:0] addr, input logic [31:0] wd);
    req_write   = wr;
    req_size    = sz;
    req_signed  = sg;
    req_address = addr;
    req_wr_data = wd;
    req_valid   = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat          = 0;
    rd_count     = 0;
    rd_addr      = '0;
    wr_en_seen   = '0;
    wr_data_seen = '0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_rd_en) begin
        rd_count++;
        rd_addr = mem_address;
      end
      if (|mem_wr_en) begin
        wr_en_seen   = mem_wr_en;
        wr_data_seen = mem_wr_data;
      end
      if (rsp_valid) break;
    end
    if (rsp_valid !== 1'b1) lat = 99;
    rsp_data_seen = rsp_rd_data;
    rsp_err_seen  = rsp_error;
    $display("txn wr=%b size=%0d signed=%b addr=%h wdata=%h -> lat=%0d data=%h err=%b wr_en=%b",
             wr, sz, sg, addr, wd, lat, rsp_data_seen, rsp_err_seen, wr_en_seen);
  endtask

  task automatic respond();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[0]      = 32'h88776655;
    mem[31]     = 32'h44332211;
    mem_rd_data = 32'h0;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_size    = 2'd0;
    req_signed  = 1'b0;
    req_address = '0;
    req_wr_data = '0;
    rsp_ready   = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_en", 32'(mem_rd_en), 32'd0);
    chk("reset_wr_en", 32'(mem_wr_en), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_error", 32'(rsp_error), 32'd0);
    chk("reset_rsp_data", rsp_rd_data, 32'h0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);

    // Store byte 0xA5 to 0x06, load it back unsigned.
    request(1'b1, 2'd0, 1'b0, 7'h06, 32'h000000A5);
    chk("sb_lat", lat, 2);
    chk("sb_wr_en", 32'(wr_en_seen), 32'b0100);
    chk("sb_wr_data", wr_data_seen, 32'h00A50000);
    chk("sb_rsp_data", rsp_data_seen, 32'h0);
    chk("sb_rsp_err", 32'(rsp_err_seen), 32'd0);
    respond();
    request(1'b0, 2'd0, 1'b0, 7'h06, 32'h0);
    chk("lbu06_lat", lat, 3);
    chk("lbu06_data", rsp_data_seen, 32'h000000A5);
    chk("lbu06_rd_addr", 32'(rd_addr), 32'h04);
    chk("lbu06_wr_en", 32'(wr_en_seen), 32'd0);
    respond();

    // Word store, then signed half and unsigned/signed byte loads.
    request(1'b1, 2'd2, 1'b0, 7'h10, 32'h8000FF80);
    chk("sw_wr_en", 32'(wr_en_seen), 32'b1111);
    chk("sw_wr_data", wr_data_seen, 32'h8000FF80);
    respond();
    request(1'b0, 2'd1, 1'b1, 7'h12, 32'h0);
    chk("lh12_data", rsp_data_seen, 32'hFFFF8000);
    respond();
    request(1'b0, 2'd0, 1'b0, 7'h10, 32'h0);
    chk("lbu10_data", rsp_data_seen, 32'h00000080);
    respond();
    request(1'b0, 2'd0, 1'b1, 7'h10, 32'h0);
    chk("lb10_data", rsp_data_seen, 32'hFFFFFF80);
    respond();
    request(1'b0, 2'd2, 1'b1, 7'h10, 32'h0);
    chk("lw10_data", rsp_data_seen, 32'h8000FF80);
    respond();

    // Half store in the upper lanes, read back both ways.
    request(1'b1, 2'd1, 1'b0, 7'h1A, 32'h0000BEEF);
    chk("sh_wr_en", 32'(wr_en_seen), 32'b1100);
    chk("sh_wr_data", wr_data_seen, 32'hBEEF0000);
    respond();
    request(1'b0, 2'd1, 1'b0, 7'h1A, 32'h0);
    chk("lhu1a_data", rsp_data_seen, 32'h0000BEEF);
    respond();
    request(1'b0, 2'd1, 1'b1, 7'h1A, 32'h0);
    chk("lh1a_data", rsp_data_seen, 32'hFFFFBEEF);
    respond();

    // Reserved size.
    request(1'b1, 2'd3, 1'b0, 7'h00, 32'h12345678);
    chk("rsvd_lat", lat, 1);
    chk("rsvd_err", 32'(rsp_err_seen), 32'd1);
    chk("rsvd_data", rsp_data_seen, 32'h0);
    chk("rsvd_rd_count", rd_count, 0);
    chk("rsvd_wr_en", 32'(wr_en_seen), 32'd0);
    respond();

    // Word-crossing accesses.
    request(1'b0, 2'd2, 1'b0, 7'h7D, 32'h0);
`ifdef BRAM_ACCESS_MISALIGNED_SPLIT_EN
    chk("x7d_lat", lat, 4);
    chk("x7d_err", 32'(rsp_err_seen), 32'd0);
    chk("x7d_data", rsp_data_seen, 32'h55443322);
    chk("x7d_rd_count", rd_count, 2);
    chk("x7d_rd_addr", 32'(rd_addr), 32'h00);
`else
    chk("x7d_lat", lat, 1);
    chk("x7d_err", 32'(rsp_err_seen), 32'd1);
    chk("x7d_data", rsp_data_seen, 32'h0);
    chk("x7d_rd_count", rd_count, 0);
`endif
    respond();
    request(1'b0, 2'd1, 1'b0, 7'h03, 32'h0);
`ifdef BRAM_ACCESS_MISALIGNED_SPLIT_EN
    chk("x03_data", rsp_data_seen, 32'h00000088);
    chk("x03_err", 32'(rsp_err_seen), 32'd0);
`else
    chk("x03_err", 32'(rsp_err_seen), 32'd1);
    chk("x03_rd_count", rd_count, 0);
`endif
    respond();

    // Response back-pressure for 5 cycles.
    request(1'b0, 2'd2, 1'b0, 7'h7C, 32'h0);
    chk("stall_lat", lat, 3);
    for (int k = 0; k < 5; k++) begin
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_data", rsp_rd_data, 32'h44332211);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    respond();
    chk("post_ack_req_ready", 32'(req_ready), 32'd1);
    chk("post_ack_rsp_valid", 32'(rsp_valid), 32'd0);

    // Reset during the ISSUE cycle of a store: write enable gated, nothing written.
    req_write   = 1'b1;
    req_size    = 2'd0;
    req_signed  = 1'b0;
    req_address = 7'h20;
    req_wr_data = 32'h0000005A;
    req_valid   = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_issue_wr_en", 32'(mem_wr_en), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_issue_rsp_valid", 32'(rsp_valid), 32'd0);
    request(1'b0, 2'd0, 1'b0, 7'h20, 32'h0);
    chk("rst_issue_readback", rsp_data_seen, 32'h0);
    respond();

    // Reset during WAIT of a load: abandoned silently.
    req_write   = 1'b0;
    req_size    = 2'd2;
    req_address = 7'h00;
    req_valid   = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_wait_rd_en", 32'(mem_rd_en), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_wait_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("rst_wait_req_ready", 32'(req_ready), 32'd1);
    request(1'b0, 2'd2, 1'b0, 7'h00, 32'h0);
    chk("after_rst_lat", lat, 3);
    chk("after_rst_data", rsp_data_seen, 32'h88776655);
    respond();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
